// File: rtl/starting_memory_controller.sv
// Builds the 48-bit starting game memory by hashing both players' private keys
// in turn on a single shared hash core.
module starting_memory_controller #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  p1_private,
    input  logic [7:0]  p2_private,
    input  logic [7:0]  p1_money,
    input  logic [7:0]  p2_money,
    output logic        hash_start,
    output logic [7:0]  hash_message,
    input  logic        hash_done,
    input  logic [7:0]  hash_value,
    output logic        busy,
    output logic        memory_valid,
    output logic        error,
    output logic [47:0] starting_memory
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE1 = 3'd1,
        S_WAIT1  = 3'd2,
        S_ISSUE2 = 3'd3,
        S_WAIT2  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 32'd1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  p1_priv_q, p1_priv_d;
    logic [7:0]  p2_priv_q, p2_priv_d;
    logic [7:0]  p1_money_q, p1_money_d;
    logic [7:0]  p2_money_q, p2_money_d;
    logic [7:0]  p1_pub_q, p1_pub_d;
    logic [7:0]  p2_pub_q, p2_pub_d;
    logic [7:0]  msg_q, msg_d;
    logic [47:0] mem_q, mem_d;
    logic        valid_q, valid_d;
    logic        error_q, error_d;

    // State register and all datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            p1_priv_q  <= 8'd0;
            p2_priv_q  <= 8'd0;
            p1_money_q <= 8'd0;
            p2_money_q <= 8'd0;
            p1_pub_q   <= 8'd0;
            p2_pub_q   <= 8'd0;
            msg_q      <= 8'd0;
            mem_q      <= 48'd0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            p1_priv_q  <= p1_priv_d;
            p2_priv_q  <= p2_priv_d;
            p1_money_q <= p1_money_d;
            p2_money_q <= p2_money_d;
            p1_pub_q   <= p1_pub_d;
            p2_pub_q   <= p2_pub_d;
            msg_q      <= msg_d;
            mem_q      <= mem_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
        end
    end

    // Next-state and datapath update; the message register is preloaded so it
    // is already stable in each ISSUE cycle, and done beats the timeout.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        p1_priv_d  = p1_priv_q;
        p2_priv_d  = p2_priv_q;
        p1_money_d = p1_money_q;
        p2_money_d = p2_money_q;
        p1_pub_d   = p1_pub_q;
        p2_pub_d   = p2_pub_q;
        msg_d      = msg_q;
        mem_d      = mem_q;
        valid_d    = valid_q;
        error_d    = error_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    p1_priv_d  = p1_private;
                    p2_priv_d  = p2_private;
                    p1_money_d = p1_money;
                    p2_money_d = p2_money;
                    msg_d      = p1_private;
                    valid_d    = 1'b0;
                    error_d    = 1'b0;
                    state_d    = S_ISSUE1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE1: begin
                cnt_d   = 8'd0;
                state_d = S_WAIT1;
            end
            S_WAIT1: begin
                if (hash_done) begin
                    p1_pub_d = hash_value;
                    msg_d    = p2_priv_q;
                    state_d  = S_ISSUE2;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_ISSUE2: begin
                cnt_d   = 8'd0;
                state_d = S_WAIT2;
            end
            S_WAIT2: begin
                if (hash_done) begin
                    p2_pub_d = hash_value;
                    state_d  = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                mem_d   = {p1_priv_q, p1_pub_q, p1_money_q,
                           p2_priv_q, p2_pub_q, p2_money_q};
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                error_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign hash_start      = (state_q == S_ISSUE1) || (state_q == S_ISSUE2);
    assign busy            = (state_q != S_IDLE);
    assign hash_message    = msg_q;
    assign memory_valid    = valid_q;
    assign error           = error_q;
    assign starting_memory = mem_q;

endmodule

// File: tb/tb_starting_memory_controller.sv
// Directed bench for starting_memory_controller with a behavioural hash core
// (message XOR 8'hA5, programmable latency, optional never-done mode).
module tb_starting_memory_controller;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  p1_private, p2_private, p1_money, p2_money;
    logic        hash_start;
    logic [7:0]  hash_message;
    logic        hash_done;
    logic [7:0]  hash_value;
    logic        busy, memory_valid, error;
    logic [47:0] starting_memory;

    int          n_checks = 0;
    int          n_fail   = 0;

    // hash core model state
    int          lat_k      = 3;
    logic        never_done = 1'b0;
    int          rem        = 0;
    logic [7:0]  cur_msg    = 8'h00;
    int          hs_count   = 0;
    logic [7:0]  msg_log [0:63];

    starting_memory_controller #(.TIMEOUT(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .p1_private      (p1_private),
        .p2_private      (p2_private),
        .p1_money        (p1_money),
        .p2_money        (p2_money),
        .hash_start      (hash_start),
        .hash_message    (hash_message),
        .hash_done       (hash_done),
        .hash_value      (hash_value),
        .busy            (busy),
        .memory_valid    (memory_valid),
        .error           (error),
        .starting_memory (starting_memory)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hash core: done is high exactly lat_k cycles after the hash_start cycle.
    always @(posedge clk) begin
        if (hash_start) begin
            if (hs_count < 64) msg_log[hs_count] <= hash_message;
            hs_count <= hs_count + 1;
            cur_msg  <= hash_message;
        end
        if (hash_start && !never_done) rem <= lat_k;
        else if (rem != 0)             rem <= rem - 1;
    end

    assign hash_done  = (rem == 1);
    assign hash_value = hash_done ? (cur_msg ^ 8'hA5) : 8'h00;

    task automatic check_eq(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; leaves the bench at the negedge of cycle 1.
    task automatic start_build(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] ma, input logic [7:0] mb);
        p1_private = a;
        p2_private = b;
        p1_money   = ma;
        p2_money   = mb;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_idle(input int first, output int n);
        n = first;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_eq("idle_bound", 48'd1, 48'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_hash_start"}, {47'd0, hash_start}, 48'd0);
        check_eq({tag, "_hash_message"}, {40'd0, hash_message}, 48'd0);
        check_eq({tag, "_busy"}, {47'd0, busy}, 48'd0);
        check_eq({tag, "_valid"}, {47'd0, memory_valid}, 48'd0);
        check_eq({tag, "_error"}, {47'd0, error}, 48'd0);
        check_eq({tag, "_memory"}, starting_memory, 48'd0);
    endtask

    initial begin
        int n;
        int hs0;
        reset = 1'b1;
        start = 1'b0;
        p1_private = 8'h00; p2_private = 8'h00;
        p1_money   = 8'h00; p2_money   = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_all_zero("reset");

        // nominal build, k=3
        @(negedge clk);
        lat_k = 3;
        hs0 = hs_count;
        start_build(8'h75, 8'h1B, 8'h32, 8'h32);
        check_eq("nom_c1_hash_start", {47'd0, hash_start}, 48'd1);
        check_eq("nom_c1_message", {40'd0, hash_message}, 48'h75);
        check_eq("nom_c1_busy", {47'd0, busy}, 48'd1);
        wait_idle(1, n);
        check_eq("nom_latency", n, 48'd10);
        check_eq("nom_valid", {47'd0, memory_valid}, 48'd1);
        check_eq("nom_error", {47'd0, error}, 48'd0);
        check_eq("nom_memory", starting_memory, 48'h75D0321BBE32);
        check_eq("nom_pulses", hs_count - hs0, 48'd2);
        check_eq("nom_msg1", {40'd0, msg_log[hs0]}, 48'h75);
        check_eq("nom_msg2", {40'd0, msg_log[hs0 + 1]}, 48'h1B);

        // timeout in WAIT1 with TIMEOUT=4
        @(negedge clk);
        never_done = 1'b1;
        hs0 = hs_count;
        start_build(8'h44, 8'h55, 8'h66, 8'h77);
        wait_idle(1, n);
        check_eq("to_busy_fall", n, 48'd7);
        check_eq("to_error", {47'd0, error}, 48'd1);
        check_eq("to_valid", {47'd0, memory_valid}, 48'd0);
        check_eq("to_pulses", hs_count - hs0, 48'd1);
        check_eq("to_memory_kept", starting_memory, 48'h75D0321BBE32);
        repeat (3) @(negedge clk);
        never_done = 1'b0;

        // start while busy is ignored
        hs0 = hs_count;
        start_build(8'h12, 8'h34, 8'h56, 8'h78);
        check_eq("sb_error_cleared", {47'd0, error}, 48'd0);
        @(negedge clk);
        p1_private = 8'hAA; p2_private = 8'hBB;
        p1_money   = 8'hCC; p2_money   = 8'hDD;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(3, n);
        check_eq("sb_memory", starting_memory, 48'h12B756349178);
        check_eq("sb_valid", {47'd0, memory_valid}, 48'd1);
        check_eq("sb_pulses", hs_count - hs0, 48'd2);
        repeat (2) @(negedge clk);
        check_eq("sb_no_restart", {47'd0, busy}, 48'd0);

        // reset in WAIT2, then a clean build
        start_build(8'h21, 8'h43, 8'h65, 8'h87);
        repeat (5) @(negedge clk);
        check_eq("rst_in_wait2_busy", {47'd0, busy}, 48'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_all_zero("midrst");
        start_build(8'h5A, 8'hC3, 8'h01, 8'hFF);
        wait_idle(1, n);
        check_eq("post_rst_latency", n, 48'd10);
        check_eq("post_rst_memory", starting_memory, 48'h5AFF01C366FF);

        // done lands in the same cycle the counter reaches TIMEOUT-1
        @(negedge clk);
        lat_k = 4;
        start_build(8'h0F, 8'hF0, 8'h11, 8'h22);
        wait_idle(1, n);
        check_eq("bnd_latency", n, 48'd12);
        check_eq("bnd_error", {47'd0, error}, 48'd0);
        check_eq("bnd_valid", {47'd0, memory_valid}, 48'd1);
        check_eq("bnd_memory", starting_memory, 48'h0FAA11F05522);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
